// File: rtl/kalman_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the Kalman frame transmitter.
package kalman_frame_pkg;

  localparam logic [7:0] HDR0_DEF  = 8'hC1;
  localparam logic [7:0] HDR1_DEF  = 8'hC2;
  localparam int         FRAME_LEN = 12;

  localparam logic [3:0] IDX_HDR1      = 4'd1;
  localparam logic [3:0] IDX_PAY_FIRST = 4'd2;
  localparam logic [3:0] IDX_LAST      = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  // XOR of the nine payload bytes (x, p, seq)
  function automatic logic [7:0] frame_csum(input logic [31:0] x, input logic [31:0] p,
                                            input logic [7:0] seq);
    return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0] ^
           p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0] ^ seq;
  endfunction

endpackage

// File: rtl/kalman_frame_tx.sv
// Snapshots filter x/p on a decimated strobe and serialises a 12-byte frame on a valid/ready byte stream.
module kalman_frame_tx
  import kalman_frame_pkg::*;
#(
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter int         DECIM_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_x,
  input  logic [31:0]        i_p,
  input  logic               i_trig,
  input  logic [DECIM_W-1:0] i_decim,
  output logic [7:0]         o_tdata,
  output logic               o_tvalid,
  input  logic               i_tready,
  output logic               o_busy,
  output logic [15:0]        o_drop_cnt
);

  state_e               state_r, state_s;
  logic [3:0]           idx_r, idx_s, nxt_idx_s;
  logic [7:0]           tdata_r, tdata_s, byte_s;
  logic                 tvalid_r, tvalid_s;
  logic [31:0]          x_sh_r, p_sh_r;
  logic [7:0]           seq_sh_r, csum_sh_r, seq_r;
  logic [DECIM_W-1:0]   dcnt_r, dec_m1_s;
  logic [15:0]          drop_r;
  logic                 sel_s, hs_s, load_s;

  // A zero decimation setting behaves as one; >= lets a shrunk setting fire on the next strobe
  assign dec_m1_s  = (i_decim == '0) ? '0 : i_decim - {{(DECIM_W-1){1'b0}}, 1'b1};
  assign sel_s     = i_trig && (dcnt_r >= dec_m1_s);
  assign hs_s      = tvalid_r && i_tready;
  assign nxt_idx_s = idx_r + 4'd1;

  // Byte to present after the current one handshakes
  always_comb begin
    byte_s = 8'h00;
    case (nxt_idx_s)
      IDX_HDR1: byte_s = HDR1;
      4'd2:     byte_s = x_sh_r[31:24];
      4'd3:     byte_s = x_sh_r[23:16];
      4'd4:     byte_s = x_sh_r[15:8];
      4'd5:     byte_s = x_sh_r[7:0];
      4'd6:     byte_s = p_sh_r[31:24];
      4'd7:     byte_s = p_sh_r[23:16];
      4'd8:     byte_s = p_sh_r[15:8];
      4'd9:     byte_s = p_sh_r[7:0];
      4'd10:    byte_s = seq_sh_r;
      4'd11:    byte_s = csum_sh_r;
      default:  byte_s = 8'h00;
    endcase
  end

  // Frame FSM next-state and registered-output next values
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    tdata_s  = tdata_r;
    tvalid_s = tvalid_r;
    load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_s) begin
          load_s   = 1'b1;
          state_s  = ST_HDR;
          idx_s    = 4'd0;
          tvalid_s = 1'b1;
          tdata_s  = HDR0;
        end else begin
          tvalid_s = 1'b0;
        end
      end
      ST_HDR, ST_PAYLOAD: begin
        if (hs_s) begin
          idx_s   = nxt_idx_s;
          tdata_s = byte_s;
          if (nxt_idx_s == IDX_PAY_FIRST) begin
            state_s = ST_PAYLOAD;
          end else if (nxt_idx_s == IDX_LAST) begin
            state_s = ST_CSUM;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_CSUM: begin
        if (hs_s) begin
          state_s  = ST_IDLE;
          idx_s    = 4'd0;
          tvalid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        idx_s    = 4'd0;
        tvalid_s = 1'b0;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= 4'd0;
      tdata_r  <= 8'h00;
      tvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      tdata_r  <= tdata_s;
      tvalid_r <= tvalid_s;
    end
  end

  // Shadow snapshot, taken only when a frame starts so later input changes cannot leak in
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_sh_r    <= 32'h0000_0000;
      p_sh_r    <= 32'h0000_0000;
      seq_sh_r  <= 8'h00;
      csum_sh_r <= 8'h00;
    end else if (load_s) begin
      x_sh_r    <= i_x;
      p_sh_r    <= i_p;
      seq_sh_r  <= seq_r;
      csum_sh_r <= frame_csum(i_x, i_p, seq_r);
    end
  end

  // Decimation counter, sequence number (advances on drops too) and saturating drop count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dcnt_r <= '0;
      seq_r  <= 8'h00;
      drop_r <= 16'h0000;
    end else begin
      if (i_trig) begin
        dcnt_r <= sel_s ? '0 : dcnt_r + {{(DECIM_W-1){1'b0}}, 1'b1};
      end
      if (sel_s) begin
        seq_r <= seq_r + 8'd1;
      end
      if (sel_s && (state_r != ST_IDLE) && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
    end
  end

  assign o_tdata    = tdata_r;
  assign o_tvalid   = tvalid_r;
  assign o_busy     = (state_r != ST_IDLE);
  assign o_drop_cnt = drop_r;

endmodule

// File: tb/tb_kalman_frame_tx.sv
// Scoreboard bench for kalman_frame_tx: frames are predicted at strobe time and popped on each handshake.
module tb_kalman_frame_tx;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_x = 32'h0;
  logic [31:0] i_p = 32'h0;
  logic        i_trig = 1'b0;
  logic [15:0] i_decim = 16'd1;
  logic        i_tready = 1'b0;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_busy;
  logic [15:0] o_drop_cnt;

  always #5 i_clk = ~i_clk;

  kalman_frame_tx dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_p(i_p), .i_trig(i_trig),
    .i_decim(i_decim), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  int         vec = 0;
  int         miss = 0;
  logic [7:0] exp_q[$];
  int         m_dcnt = 0;
  bit         m_busy = 1'b0;
  int         m_hs = 0;
  logic [7:0] m_seq = 8'h00;
  int         m_drop = 0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic model_clear();
    exp_q.delete();
    m_dcnt = 0; m_busy = 1'b0; m_hs = 0; m_seq = 8'h00; m_drop = 0; stall_pend = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] x, input logic [31:0] p, input logic [7:0] s);
    logic [7:0] b[12];
    b[0] = 8'hC1; b[1] = 8'hC2;
    for (int k = 0; k < 4; k++) begin
      b[2+k] = x[31-8*k -: 8];
      b[6+k] = p[31-8*k -: 8];
    end
    b[10] = s;
    b[11] = 8'h00;
    for (int k = 2; k <= 10; k++) b[11] = b[11] ^ b[k];
    for (int k = 0; k < 12; k++) exp_q.push_back(b[k]);
  endtask

  // One clock: drive inputs, observe at negedge, update the reference model, advance past posedge.
  task automatic step(input logic trig, input logic rdy, input logic [31:0] x, input logic [31:0] p);
    int dm1;
    logic [7:0] e;
    i_trig = trig;
    i_tready = rdy;
    if (trig) begin
      i_x = x; i_p = p;
    end else begin
      i_x = $urandom; i_p = $urandom;
    end
    @(negedge i_clk);
    if (stall_pend) begin
      vec++;
      if (!(o_tvalid === 1'b1 && o_tdata === stall_data)) begin
        miss++;
        $display("FAIL stall_hold tvalid=%b tdata=%h required tvalid=1 tdata=%h", o_tvalid, o_tdata, stall_data);
      end
    end
    if (o_tvalid === 1'b1 && i_tready) begin
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_byte got %h while no byte expected", o_tdata);
      end else begin
        e = exp_q.pop_front();
        if (o_tdata !== e) begin
          miss++;
          $display("FAIL frame_byte got %h expected %h", o_tdata, e);
        end
      end
      if (m_busy) m_hs++;
    end
    stall_pend = (o_tvalid === 1'b1) && !i_tready;
    stall_data = o_tdata;
    if (trig) begin
      dm1 = (i_decim == 16'd0) ? 0 : int'(i_decim) - 1;
      if (m_dcnt >= dm1) begin
        m_dcnt = 0;
        if (m_busy) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          push_frame(x, p, m_seq);
          m_busy = 1'b1;
          m_hs = 0;
        end
        m_seq = m_seq + 8'd1;
      end else begin
        m_dcnt++;
      end
    end
    if (m_busy && m_hs >= 12) begin
      m_busy = 1'b0;
      m_hs = 0;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 400) begin
      step(1'b0, 1'b1, 32'h0, 32'h0);
      n++;
    end
    vec++;
    if (n >= 400) begin
      miss++;
      $display("FAIL drain_timeout remaining=%0d bytes expected 0", exp_q.size());
      exp_q.delete();
      m_busy = 1'b0;
    end
    vec++;
    if (o_tvalid !== 1'b0) begin
      miss++;
      $display("FAIL idle_gap tvalid=%b expected 0", o_tvalid);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #3;
    vec += 4;
    if (o_tvalid !== 1'b0) begin miss++; $display("FAIL rst_tvalid got %b expected 0", o_tvalid); end
    if (o_tdata !== 8'h00) begin miss++; $display("FAIL rst_tdata got %h expected 00", o_tdata); end
    if (o_busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %b expected 0", o_busy); end
    if (o_drop_cnt !== 16'h0) begin miss++; $display("FAIL rst_drop got %h expected 0000", o_drop_cnt); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    model_clear();
  endtask

  task automatic test_basic();
    i_decim = 16'd1;
    step(1'b1, 1'b1, 32'h0000_0064, 32'h0000_0200);
    vec++;
    if (o_busy !== 1'b1 || o_tvalid !== 1'b1) begin
      miss++;
      $display("FAIL start_latency busy=%b tvalid=%b expected 1 1", o_busy, o_tvalid);
    end
    drain();
    vec++;
    if (o_drop_cnt !== m_drop[15:0]) begin miss++; $display("FAIL basic_drop got %h expected %h", o_drop_cnt, m_drop[15:0]); end
  endtask

  task automatic test_backpressure();
    int c = 0;
    step(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0200);
    while ((exp_q.size() != 0 || m_busy) && c < 200) begin
      step(1'b0, (c % 3) == 0, 32'h0, 32'h0);
      c++;
    end
    vec++;
    if (c >= 200) begin miss++; $display("FAIL bp_timeout remaining=%0d expected 0", exp_q.size()); end
    drain();
  endtask

  task automatic test_decim();
    i_decim = 16'd4;
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 1'b1, $urandom, $urandom);
      repeat (19) step(1'b0, 1'b1, 32'h0, 32'h0);
    end
    step(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);
    step(1'b1, 1'b1, 32'h5555_6666, 32'h7777_8888);
    i_decim = 16'd2;
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    drain();
    vec++;
    if (o_drop_cnt !== m_drop[15:0]) begin miss++; $display("FAIL decim_drop got %h expected %h", o_drop_cnt, m_drop[15:0]); end
  endtask

  task automatic test_drops();
    i_decim = 16'd1;
    for (int s = 0; s < 12; s++) begin
      step(1'b1, 1'b1, $urandom, $urandom);
      repeat (4) step(1'b0, 1'b1, 32'h0, 32'h0);
    end
    drain();
    vec++;
    if (o_drop_cnt !== m_drop[15:0]) begin miss++; $display("FAIL drops5_cnt got %h expected %h", o_drop_cnt, m_drop[15:0]); end
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 1'b1, $urandom, $urandom);
      repeat (11) step(1'b0, 1'b1, 32'h0, 32'h0);
    end
    drain();
    vec++;
    if (o_drop_cnt !== m_drop[15:0]) begin miss++; $display("FAIL drops12_cnt got %h expected %h", o_drop_cnt, m_drop[15:0]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    i_decim = 16'd1;
    step(1'b1, 1'b1, 32'hA5A5_5A5A, 32'h0F0F_F0F0);
    while (m_hs < 6 && n < 50) begin
      step(1'b0, 1'b1, 32'h0, 32'h0);
      n++;
    end
    i_rst_n = 1'b0;
    #1;
    vec += 2;
    if (o_tvalid !== 1'b0) begin miss++; $display("FAIL midrst_tvalid got %b expected 0", o_tvalid); end
    if (o_busy !== 1'b0 || o_drop_cnt !== 16'h0) begin
      miss++;
      $display("FAIL midrst_state busy=%b drop=%h expected 0 0000", o_busy, o_drop_cnt);
    end
    model_clear();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (5) step(1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    drain();
  endtask

  task automatic test_wrap();
    i_decim = 16'd0;
    for (int f = 0; f < 257; f++) begin
      step(1'b1, 1'b1, $urandom, $urandom);
      repeat (12) step(1'b0, 1'b1, 32'h0, 32'h0);
    end
    drain();
    vec++;
    if (o_drop_cnt !== m_drop[15:0]) begin miss++; $display("FAIL wrap_drop got %h expected %h", o_drop_cnt, m_drop[15:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_decim();
    test_drops();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
